// File: rtl/glitch_cmd_loader_pkg.sv
// Shared definitions for the glitch command loader: FSM states, status codes
// and the layout of a packed command word.
package glitch_defs;

    localparam int WORD_W    = 32;
    localparam int DELAY_LSB = 16;
    localparam int WIDTH_LSB = 8;
    localparam int MODE_LSB  = 0;

    typedef enum logic [2:0] {
        LOADER_STATE_IDLE,
        LOADER_STATE_COUNT,
        LOADER_STATE_DATA,
        LOADER_STATE_CSUM,
        LOADER_STATE_PAD,
        LOADER_STATE_RESP
    } loader_state_t;

    localparam logic [7:0] RESP_ACK     = 8'h06;
    localparam logic [7:0] RESP_CSUM    = 8'h15;
    localparam logic [7:0] RESP_LEN     = 8'h16;
    localparam logic [7:0] RESP_BUSY    = 8'h17;
    localparam logic [7:0] RESP_TIMEOUT = 8'h18;

    // Entry bytes arrive delay-high first: {delay[15:8], delay[7:0], width, mode}.
    function automatic logic [WORD_W-1:0] pack_word(input logic [7:0] b0, input logic [7:0] b1,
                                                    input logic [7:0] b2, input logic [7:0] b3);
        logic [WORD_W-1:0] w;
        w = '0;
        w[DELAY_LSB +: 16] = {b0, b1};
        w[WIDTH_LSB +: 8]  = b2;
        w[MODE_LSB +: 8]   = b3;
        return w;
    endfunction

endpackage

// File: rtl/glitch_cmd_loader_if.sv
// Byte-link, FIFO-write and status signals between the loader and its neighbours.
interface glitch_cmd_loader_if;
    import glitch_defs::*;

    logic [7:0]        rx_data;
    logic              rx_valid;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [WORD_W-1:0] fifo_data;
    logic              fifo_we;
    logic              fifo_full;
    logic              fifo_clr;
    logic              glitch_ready;
    logic              busy;

    modport master (
        input  rx_data, rx_valid, tx_ready, fifo_full, glitch_ready,
        output tx_data, tx_valid, fifo_data, fifo_we, fifo_clr, busy
    );

    modport slave (
        output rx_data, rx_valid, tx_ready, fifo_full, glitch_ready,
        input  tx_data, tx_valid, fifo_data, fifo_we, fifo_clr, busy
    );
endinterface

// File: rtl/glitch_cmd_loader.sv
// Parses host command frames into 32-bit glitch entries, loads and pads the
// command FIFO, and returns a one-byte status.
module glitch_cmd_loader
    import glitch_defs::*;
#(
    parameter int         FIFO_DEPTH     = 16,
    parameter int         TIMEOUT_CYCLES = 1200000,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5
) (
    input  logic                clk_in,
    input  logic                rst,
    glitch_cmd_loader_if.master bus
);

    localparam int ENT_W = $clog2(FIFO_DEPTH + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0]       MAX_N   = 8'(FIFO_DEPTH);
    localparam logic [ENT_W-1:0] ENT_ONE = ENT_W'(1);
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYCLES);

    loader_state_t     state_q, state_d;
    logic [ENT_W-1:0]  n_q, n_d;
    logic [ENT_W-1:0]  ent_q, ent_d;
    logic [1:0]        idx_q, idx_d;
    logic [23:0]       asm_q, asm_d;
    logic [WORD_W-1:0] hold_q, hold_d;
    logic [7:0]        csum_q, csum_d;
    logic [7:0]        code_q, code_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;

    logic              fifo_we_o;
    logic              fifo_clr_o;
    logic [WORD_W-1:0] fifo_data_o;
    logic              timed;
    logic              tmo_hit;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q <= LOADER_STATE_IDLE;
            n_q     <= '0;
            ent_q   <= '0;
            idx_q   <= '0;
            asm_q   <= '0;
            hold_q  <= '0;
            csum_q  <= '0;
            code_q  <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            ent_q   <= ent_d;
            idx_q   <= idx_d;
            asm_q   <= asm_d;
            hold_q  <= hold_d;
            csum_q  <= csum_d;
            code_q  <= code_d;
            tmo_q   <= tmo_d;
        end
    end

    assign timed   = (state_q == LOADER_STATE_COUNT) || (state_q == LOADER_STATE_DATA) ||
                     (state_q == LOADER_STATE_CSUM);
    // An arriving byte always takes priority over an expiring timer.
    assign tmo_hit = timed && !bus.rx_valid && (tmo_q == TMO_MAX);

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        ent_d       = ent_q;
        idx_d       = idx_q;
        asm_d       = asm_q;
        hold_d      = hold_q;
        csum_d      = csum_q;
        code_d      = code_q;
        fifo_we_o   = 1'b0;
        fifo_clr_o  = 1'b0;
        fifo_data_o = '0;

        if (!timed || bus.rx_valid) tmo_d = '0;
        else                        tmo_d = tmo_q + 1'b1;

        case (state_q)
            LOADER_STATE_IDLE: begin
                if (bus.rx_valid && bus.rx_data == SYNC_BYTE) begin
                    if (bus.glitch_ready) begin
                        state_d = LOADER_STATE_COUNT;
                        ent_d   = '0;
                        idx_d   = '0;
                        hold_d  = '0;
                    end else begin
                        code_d  = RESP_BUSY;
                        state_d = LOADER_STATE_RESP;
                    end
                end
            end
            LOADER_STATE_COUNT: begin
                if (bus.rx_valid) begin
                    if (bus.rx_data == 8'd0 || bus.rx_data > MAX_N) begin
                        code_d  = RESP_LEN;
                        state_d = LOADER_STATE_RESP;
                    end else begin
                        n_d     = bus.rx_data[ENT_W-1:0];
                        csum_d  = bus.rx_data;
                        state_d = LOADER_STATE_DATA;
                    end
                end
            end
            LOADER_STATE_DATA: begin
                if (bus.rx_valid) begin
                    csum_d = csum_q ^ bus.rx_data;
                    asm_d  = {asm_q[15:0], bus.rx_data};
                    idx_d  = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        // The newest entry is held back; only its predecessor goes to the FIFO.
                        if (ent_q != '0 && bus.fifo_full) begin
                            fifo_clr_o = 1'b1;
                            hold_d     = '0;
                            code_d     = RESP_LEN;
                            state_d    = LOADER_STATE_RESP;
                        end else begin
                            fifo_we_o   = (ent_q != '0);
                            fifo_data_o = hold_q;
                            hold_d      = pack_word(asm_q[23:16], asm_q[15:8], asm_q[7:0], bus.rx_data);
                            ent_d       = ent_q + ENT_ONE;
                            if (ent_q + ENT_ONE == n_q) state_d = LOADER_STATE_CSUM;
                        end
                    end
                end
            end
            LOADER_STATE_CSUM: begin
                if (bus.rx_valid) begin
                    if (bus.rx_data == csum_q) begin
                        fifo_we_o   = 1'b1;
                        fifo_data_o = hold_q;
                        state_d     = LOADER_STATE_PAD;
                    end else begin
                        fifo_clr_o = 1'b1;
                        code_d     = RESP_CSUM;
                        state_d    = LOADER_STATE_RESP;
                    end
                    hold_d = '0;
                end
            end
            LOADER_STATE_PAD: begin
                if (bus.fifo_full) begin
                    code_d  = RESP_ACK;
                    state_d = LOADER_STATE_RESP;
                end else begin
                    fifo_we_o = 1'b1;
                end
            end
            LOADER_STATE_RESP: begin
                if (bus.tx_ready) state_d = LOADER_STATE_IDLE;
            end
            default: state_d = LOADER_STATE_IDLE;
        endcase

        if (tmo_hit) begin
            fifo_clr_o = 1'b1;
            hold_d     = '0;
            code_d     = RESP_TIMEOUT;
            state_d    = LOADER_STATE_RESP;
        end
    end

    assign bus.fifo_we   = fifo_we_o;
    assign bus.fifo_clr  = fifo_clr_o;
    assign bus.fifo_data = fifo_data_o;
    assign bus.tx_valid  = (state_q == LOADER_STATE_RESP);
    assign bus.tx_data   = (state_q == LOADER_STATE_RESP) ? code_q : 8'h00;
    assign bus.busy      = (state_q != LOADER_STATE_IDLE);

endmodule

// File: tb/tb_glitch_cmd_loader.sv
// Randomized frame bench: a frame-level model predicts FIFO writes, flushes and
// the status byte; a per-cycle monitor checks them against the DUT.
module tb_glitch_cmd_loader;
    import glitch_defs::*;

    localparam int DEPTH = 16;
    localparam int TMO   = 300;
    localparam logic [31:0] FILL_BASE = 32'hDEAD_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    glitch_cmd_loader_if bus();

    glitch_cmd_loader #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO), .SYNC_BYTE(8'hA5)) dut (
        .clk_in(clk),
        .rst   (rst),
        .bus   (bus)
    );

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;
    int clr_cnt = 0;
    int clr_cyc = 0;
    int last_strobe = 0;

    logic [31:0] fq[$];
    logic [31:0] exp_wr[$];
    logic [7:0]  fixed_q[$];
    logic [7:0]  model_csum;
    logic [31:0] model_w0;

    logic        we_s = 1'b0, clr_s = 1'b0;
    logic [31:0] data_s = '0;
    logic        txv_prev = 1'b0, tready_prev = 1'b0, rst_prev = 1'b1;
    logic [7:0]  txd_prev = '0;
    bit          fill_tog = 1'b0, fill_seen = 1'b0;
    int          fill_n = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Per-cycle monitor, sampling mid-cycle.
    always @(negedge clk) begin
        we_s   = bus.fifo_we;
        clr_s  = bus.fifo_clr;
        data_s = bus.fifo_data;
        if (bus.fifo_we) begin
            if (exp_wr.size() == 0) check("unexpected_fifo_we", bus.fifo_data, 32'hxxxx_xxxx);
            else                    check("fifo_data", bus.fifo_data, exp_wr.pop_front());
            check("we_while_full", bus.fifo_full, 1'b0);
            check("we_with_clr", bus.fifo_clr, 1'b0);
        end
        if (bus.fifo_clr) begin
            clr_cnt++;
            clr_cyc = cyc;
        end
        if (txv_prev && !tready_prev && !rst_prev) begin
            check("tx_valid_held", bus.tx_valid, 1'b1);
            check("tx_data_held", bus.tx_data, txd_prev);
        end
        txv_prev    = bus.tx_valid;
        txd_prev    = bus.tx_data;
        tready_prev = bus.tx_ready;
        rst_prev    = rst;
        cyc++;
    end

    // FIFO model: applies the sampled strobes at the edge, registered full flag.
    always @(posedge clk) begin
        if (fill_tog != fill_seen) begin
            fq.delete();
            for (int i = 0; i < fill_n; i++) fq.push_back(FILL_BASE + 32'(i));
            fill_seen = fill_tog;
        end else if (clr_s) begin
            fq.delete();
        end else if (we_s && fq.size() < DEPTH) begin
            fq.push_back(data_s);
        end
        bus.fifo_full <= (fq.size() >= DEPTH);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fill(input int p);
        fill_n   = p;
        fill_tog = ~fill_tog;
        step();
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        last_strobe  = cyc;
        step();
        bus.rx_valid = 1'b0;
        repeat (gap) step();
    endtask

    // csum_ov: -1 send correct checksum, -2 send a corrupted one, >=0 send that byte.
    task automatic run_frame(input int n, input int prefill, input bit ready,
                             input int csum_ov, input int stall_after, input int hold_cycles);
        logic [7:0]  eb[$];
        logic [7:0]  tx_b[$];
        logic [31:0] w[$];
        logic [31:0] ef[$];
        logic [7:0]  cs, code, b, bad;
        int exp_clr, ovf_k, t, delay;

        set_fill(prefill);
        clr_cnt = 0;
        exp_clr = 0;
        for (int i = 0; i < prefill; i++) ef.push_back(FILL_BASE + 32'(i));
        bus.glitch_ready = ready;
        repeat ($urandom_range(0, 2)) begin
            b = 8'($urandom);
            if (b == 8'hA5) b = 8'h5A;
            tx_b.push_back(b);
        end
        tx_b.push_back(8'hA5);

        if (!ready) begin
            code = RESP_BUSY;
        end else begin
            tx_b.push_back(8'(n));
            if (n == 0 || n > DEPTH) begin
                code = RESP_LEN;
            end else begin
                cs = 8'(n);
                for (int i = 0; i < n * 4; i++) begin
                    b = (i < fixed_q.size()) ? fixed_q[i] : 8'($urandom);
                    eb.push_back(b);
                    cs ^= b;
                end
                for (int k = 0; k < n; k++)
                    w.push_back({eb[4*k], eb[4*k+1], eb[4*k+2], eb[4*k+3]});
                model_csum = cs;
                model_w0   = w[0];
                ovf_k = -1;
                for (int k = 1; k < n; k++)
                    if (ovf_k < 0 && prefill + k - 1 >= DEPTH) ovf_k = k;

                if (stall_after >= 0) begin
                    for (int i = 0; i < stall_after; i++) tx_b.push_back(eb[i]);
                    for (int j = 0; j < stall_after / 4 - 1; j++) exp_wr.push_back(w[j]);
                    code = RESP_TIMEOUT; exp_clr = 1; ef.delete();
                end else if (ovf_k >= 0) begin
                    for (int i = 0; i < 4 * (ovf_k + 1); i++) tx_b.push_back(eb[i]);
                    for (int j = 0; j < ovf_k - 1; j++) exp_wr.push_back(w[j]);
                    code = RESP_LEN; exp_clr = 1; ef.delete();
                end else begin
                    foreach (eb[i]) tx_b.push_back(eb[i]);
                    for (int j = 0; j < n - 1; j++) exp_wr.push_back(w[j]);
                    if (csum_ov == -2) bad = cs ^ 8'($urandom_range(1, 255));
                    else               bad = 8'(csum_ov);
                    if (csum_ov != -1 && bad != cs) begin
                        tx_b.push_back(bad);
                        code = RESP_CSUM; exp_clr = 1; ef.delete();
                    end else begin
                        tx_b.push_back(cs);
                        exp_wr.push_back(w[n-1]);
                        foreach (w[j]) ef.push_back(w[j]);
                        while (ef.size() < DEPTH) ef.push_back(32'h0);
                        code = RESP_ACK;
                    end
                end
            end
        end

        foreach (tx_b[i]) send_byte(tx_b[i], $urandom_range(0, 3));

        t = 0;
        while (!bus.tx_valid && t < TMO + 400) begin
            step();
            t++;
        end
        check("tx_valid_rise", bus.tx_valid, 1'b1);
        check("tx_data", bus.tx_data, code);
        check("busy_in_resp", bus.busy, 1'b1);
        if (stall_after >= 0) begin
            delay = clr_cyc - last_strobe;
            check("timeout_delay_ok", 32'(delay >= TMO && delay <= TMO + 2), 32'd1);
        end
        repeat (hold_cycles) step();
        if (hold_cycles > 0) begin
            check("tx_valid_stall", bus.tx_valid, 1'b1);
            check("tx_data_stall", bus.tx_data, code);
        end
        bus.tx_ready = 1'b1;
        step();
        bus.tx_ready = 1'b0;
        check("tx_valid_drop", bus.tx_valid, 1'b0);
        check("busy_idle", bus.busy, 1'b0);
        check("fifo_clr_count", clr_cnt, exp_clr);
        check("missing_writes", exp_wr.size(), 0);
        exp_wr.delete();
        check("fifo_level", fq.size(), ef.size());
        if (fq.size() == ef.size())
            foreach (ef[i]) check("fifo_entry", fq[i], ef[i]);
        $display("frame n=%0d prefill=%0d ready=%0d code=%02h clr=%0d", n, prefill, ready, code, exp_clr);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_tx_valid"}, bus.tx_valid, 1'b0);
        check({tag, "_tx_data"}, bus.tx_data, 8'h00);
        check({tag, "_fifo_we"}, bus.fifo_we, 1'b0);
        check({tag, "_fifo_clr"}, bus.fifo_clr, 1'b0);
        check({tag, "_fifo_data"}, bus.fifo_data, 32'h0);
        check({tag, "_busy"}, bus.busy, 1'b0);
    endtask

    initial begin
        bus.rx_data      = 8'h00;
        bus.rx_valid     = 1'b0;
        bus.tx_ready     = 1'b0;
        bus.glitch_ready = 1'b1;
        rst = 1'b1;
        repeat (4) step();
        check_outputs_zero("reset");
        rst = 1'b0;
        step();

        // Single entry, fixed bytes: checksum and word layout pinned by hand.
        fixed_q = '{8'h00, 8'h0A, 8'h05, 8'h01};
        run_frame(1, 0, 1'b1, -1, -1, 0);
        check("model_csum_t1", model_csum, 8'h0F);
        check("model_word_t1", model_w0, 32'h000A0501);
        check("fifo_size_t1", fq.size(), 16);
        if (fq.size() == 16) begin
            check("fifo0_t1", fq[0], 32'h000A0501);
            check("fifo15_t1", fq[15], 32'h0);
        end

        run_frame(16, 0, 1'b1, -1, -1, 0);

        fixed_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        run_frame(2, 0, 1'b1, 0, -1, 0);
        check("model_csum_t3", model_csum, 8'h8A);
        fixed_q.delete();

        run_frame(0, 0, 1'b1, -1, -1, 0);
        run_frame(17, 0, 1'b1, -1, -1, 0);
        run_frame(3, 0, 1'b0, -1, -1, 0);
        run_frame(2, 0, 1'b1, -1, 3, 0);
        run_frame(3, 0, 1'b1, -1, 9, 0);
        run_frame(2, 0, 1'b1, -1, 0, 0);
        run_frame(4, 0, 1'b1, -1, -1, 50);
        run_frame(16, 3, 1'b1, -1, -1, 0);

        // Reset in the middle of DATA abandons the frame silently.
        set_fill(0);
        clr_cnt = 0;
        bus.glitch_ready = 1'b1;
        send_byte(8'hA5, 0);
        send_byte(8'h03, 1);
        for (int i = 0; i < 5; i++) send_byte(8'($urandom), 0);
        rst = 1'b1;
        step();
        check_outputs_zero("mid_rst");
        rst = 1'b0;
        step();
        check("mid_rst_fifo", fq.size(), 0);
        check("mid_rst_clr", clr_cnt, 0);
        $display("mid-frame reset applied");
        run_frame(3, 0, 1'b1, -1, -1, 0);

        for (int f = 0; f < 24; f++) begin
            int kind, n;
            kind = $urandom_range(0, 5);
            n    = $urandom_range(1, 16);
            case (kind)
                0, 1: run_frame(n, $urandom_range(0, 16 - n), 1'b1, -1, -1, $urandom_range(0, 4));
                2:    run_frame(n, 0, 1'b1, -2, -1, $urandom_range(0, 4));
                3:    run_frame(($urandom_range(0, 1) != 0) ? 0 : $urandom_range(17, 255), 0, 1'b1, -1, -1, 0);
                4:    run_frame(n, 0, 1'b0, -1, -1, 0);
                default: run_frame(16, $urandom_range(2, 8), 1'b1, -1, -1, 0);
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
